// File: rtl/pipe_id_ex_if.sv
// ID/EX boundary bundle: decode-side _IN fields and execute-side _OUT fields.
// PC_IN/PC_OUT exist only when PIPE_ID_EX_PC_EN is defined.
interface pipe_id_ex_if #(parameter int WIDTH = 32);
  logic             STALL_IN;
  logic             FLUSH_IN;
  logic [3:0]       ALUOP_IN;
  logic             ALUSRC_IN;
  logic             REGWRITE_IN;
  logic             MEMTOREG_IN;
  logic             MEMWRITE_IN;
  logic             MEMREAD_IN;
  logic [4:0]       ARS1_IN;
  logic [4:0]       ARS2_IN;
  logic [4:0]       ARD_IN;
  logic [WIDTH-1:0] RS1_IN;
  logic [WIDTH-1:0] RS2_IN;
  logic [WIDTH-1:0] IMMEDIATE_IN;
  logic [3:0]       ALUOP_OUT;
  logic             ALUSRC_OUT;
  logic             REGWRITE_OUT;
  logic             MEMTOREG_OUT;
  logic             MEMWRITE_OUT;
  logic             MEMREAD_OUT;
  logic [4:0]       ARS1_OUT;
  logic [4:0]       ARS2_OUT;
  logic [4:0]       ARD_OUT;
  logic [WIDTH-1:0] RS1_OUT;
  logic [WIDTH-1:0] RS2_OUT;
  logic [WIDTH-1:0] IMMEDIATE_OUT;
`ifdef PIPE_ID_EX_PC_EN
  logic [WIDTH-1:0] PC_IN;
  logic [WIDTH-1:0] PC_OUT;
`endif

  // master: decode stage / hazard unit side; slave: the pipeline register itself
  modport master (
`ifdef PIPE_ID_EX_PC_EN
    output PC_IN, input PC_OUT,
`endif
    output STALL_IN, FLUSH_IN, ALUOP_IN, ALUSRC_IN, REGWRITE_IN, MEMTOREG_IN,
    output MEMWRITE_IN, MEMREAD_IN, ARS1_IN, ARS2_IN, ARD_IN, RS1_IN, RS2_IN,
    output IMMEDIATE_IN,
    input  ALUOP_OUT, ALUSRC_OUT, REGWRITE_OUT, MEMTOREG_OUT, MEMWRITE_OUT,
    input  MEMREAD_OUT, ARS1_OUT, ARS2_OUT, ARD_OUT, RS1_OUT, RS2_OUT,
    input  IMMEDIATE_OUT
  );

  modport slave (
`ifdef PIPE_ID_EX_PC_EN
    input PC_IN, output PC_OUT,
`endif
    input  STALL_IN, FLUSH_IN, ALUOP_IN, ALUSRC_IN, REGWRITE_IN, MEMTOREG_IN,
    input  MEMWRITE_IN, MEMREAD_IN, ARS1_IN, ARS2_IN, ARD_IN, RS1_IN, RS2_IN,
    input  IMMEDIATE_IN,
    output ALUOP_OUT, ALUSRC_OUT, REGWRITE_OUT, MEMTOREG_OUT, MEMWRITE_OUT,
    output MEMREAD_OUT, ARS1_OUT, ARS2_OUT, ARD_OUT, RS1_OUT, RS2_OUT,
    output IMMEDIATE_OUT
  );
endinterface

// File: rtl/pipe_id_ex_reg.sv
// ID/EX pipeline register, 1-cycle latency; priority rst > flush (bubble) > stall (hold) > load.
// Optional PC field is enabled by defining PIPE_ID_EX_PC_EN.
module pipe_id_ex_reg #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  pipe_id_ex_if.slave   bus
);

  typedef struct packed {
`ifdef PIPE_ID_EX_PC_EN
    logic [WIDTH-1:0] pc;
`endif
    logic [3:0]       aluop;
    logic             alusrc;
    logic             regwrite;
    logic             memtoreg;
    logic             memwrite;
    logic             memread;
    logic [4:0]       ars1;
    logic [4:0]       ars2;
    logic [4:0]       ard;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic [WIDTH-1:0] imm;
  } stage_t;

  stage_t w_stage_in;
  stage_t r_stage;

  always_comb begin
    w_stage_in          = '0;
`ifdef PIPE_ID_EX_PC_EN
    w_stage_in.pc       = bus.PC_IN;
`endif
    w_stage_in.aluop    = bus.ALUOP_IN;
    w_stage_in.alusrc   = bus.ALUSRC_IN;
    w_stage_in.regwrite = bus.REGWRITE_IN;
    w_stage_in.memtoreg = bus.MEMTOREG_IN;
    w_stage_in.memwrite = bus.MEMWRITE_IN;
    w_stage_in.memread  = bus.MEMREAD_IN;
    w_stage_in.ars1     = bus.ARS1_IN;
    w_stage_in.ars2     = bus.ARS2_IN;
    w_stage_in.ard      = bus.ARD_IN;
    w_stage_in.rs1      = bus.RS1_IN;
    w_stage_in.rs2      = bus.RS2_IN;
    w_stage_in.imm      = bus.IMMEDIATE_IN;
  end

  // Clearing with a constant keeps X on the data inputs out of the flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= '0;
    end else if (bus.FLUSH_IN) begin
      r_stage <= '0;
    end else if (!bus.STALL_IN) begin
      r_stage <= w_stage_in;
    end
  end

`ifdef PIPE_ID_EX_PC_EN
  assign bus.PC_OUT        = r_stage.pc;
`endif
  assign bus.ALUOP_OUT     = r_stage.aluop;
  assign bus.ALUSRC_OUT    = r_stage.alusrc;
  assign bus.REGWRITE_OUT  = r_stage.regwrite;
  assign bus.MEMTOREG_OUT  = r_stage.memtoreg;
  assign bus.MEMWRITE_OUT  = r_stage.memwrite;
  assign bus.MEMREAD_OUT   = r_stage.memread;
  assign bus.ARS1_OUT      = r_stage.ars1;
  assign bus.ARS2_OUT      = r_stage.ars2;
  assign bus.ARD_OUT       = r_stage.ard;
  assign bus.RS1_OUT       = r_stage.rs1;
  assign bus.RS2_OUT       = r_stage.rs2;
  assign bus.IMMEDIATE_OUT = r_stage.imm;

endmodule

// File: tb/tb_pipe_id_ex_reg.sv
// Bench for pipe_id_ex_reg: directed vectors feed an expected-value queue that a monitor
// drains one entry per clock edge.
module tb_pipe_id_ex_reg;

  typedef struct packed {
`ifdef PIPE_ID_EX_PC_EN
    logic [31:0] pc;
`endif
    logic [3:0]  aluop;
    logic        alusrc;
    logic        regwrite;
    logic        memtoreg;
    logic        memwrite;
    logic        memread;
    logic [4:0]  ars1;
    logic [4:0]  ars2;
    logic [4:0]  ard;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
  } fld_t;

  typedef struct {
    fld_t  exp;
    string name;
  } sb_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  bit   stim_done;
  sb_t  sb_q[$];
  fld_t vec_a;
  fld_t vec_b;
  fld_t zero;

  pipe_id_ex_if #(.WIDTH(32)) bus ();

  pipe_id_ex_reg #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fld_t sample_out();
    fld_t f;
    f = '0;
`ifdef PIPE_ID_EX_PC_EN
    f.pc       = bus.PC_OUT;
`endif
    f.aluop    = bus.ALUOP_OUT;
    f.alusrc   = bus.ALUSRC_OUT;
    f.regwrite = bus.REGWRITE_OUT;
    f.memtoreg = bus.MEMTOREG_OUT;
    f.memwrite = bus.MEMWRITE_OUT;
    f.memread  = bus.MEMREAD_OUT;
    f.ars1     = bus.ARS1_OUT;
    f.ars2     = bus.ARS2_OUT;
    f.ard      = bus.ARD_OUT;
    f.rs1      = bus.RS1_OUT;
    f.rs2      = bus.RS2_OUT;
    f.imm      = bus.IMMEDIATE_OUT;
    return f;
  endfunction

  // Drive one cycle of stimulus away from the active edge and queue what must appear after it.
  task automatic step(input string name, input logic rst_v, input logic stall_v,
                      input logic flush_v, input fld_t v, input fld_t exp);
    sb_t e;
    @(negedge clk);
    rst              = rst_v;
    bus.STALL_IN     = stall_v;
    bus.FLUSH_IN     = flush_v;
`ifdef PIPE_ID_EX_PC_EN
    bus.PC_IN        = v.pc;
`endif
    bus.ALUOP_IN     = v.aluop;
    bus.ALUSRC_IN    = v.alusrc;
    bus.REGWRITE_IN  = v.regwrite;
    bus.MEMTOREG_IN  = v.memtoreg;
    bus.MEMWRITE_IN  = v.memwrite;
    bus.MEMREAD_IN   = v.memread;
    bus.ARS1_IN      = v.ars1;
    bus.ARS2_IN      = v.ars2;
    bus.ARD_IN       = v.ard;
    bus.RS1_IN       = v.rs1;
    bus.RS2_IN       = v.rs2;
    bus.IMMEDIATE_IN = v.imm;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Monitor: each rising edge produces one registered result, checked 1 time unit later.
  initial begin
    sb_t  e;
    fld_t act;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e   = sb_q.pop_front();
        act = sample_out();
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    stim_done = 1'b0;
    zero      = '0;

    vec_a = '0;
`ifdef PIPE_ID_EX_PC_EN
    vec_a.pc = 32'h0000_0040;
`endif
    vec_a.aluop = 4'b1010; vec_a.alusrc = 1'b1; vec_a.regwrite = 1'b1;
    vec_a.memtoreg = 1'b0; vec_a.memwrite = 1'b1; vec_a.memread = 1'b0;
    vec_a.ars1 = 5'd1; vec_a.ars2 = 5'd2; vec_a.ard = 5'd3;
    vec_a.rs1 = 32'hAAAA_AAAA; vec_a.rs2 = 32'h5555_5555; vec_a.imm = 32'h1234_5678;

    vec_b = '0;
`ifdef PIPE_ID_EX_PC_EN
    vec_b.pc = 32'h0000_0080;
`endif
    vec_b.aluop = 4'b0101; vec_b.alusrc = 1'b0; vec_b.regwrite = 1'b0;
    vec_b.memtoreg = 1'b1; vec_b.memwrite = 1'b0; vec_b.memread = 1'b1;
    vec_b.ars1 = 5'd4; vec_b.ars2 = 5'd5; vec_b.ard = 5'd6;
    vec_b.rs1 = 32'hFFFF_FFFF; vec_b.rs2 = 32'h0000_0000; vec_b.imm = 32'h8765_4321;

    rst = 1'b1;
    bus.STALL_IN = 1'b0;
    bus.FLUSH_IN = 1'b0;

    step("reset",          1'b1, 1'b0, 1'b0, vec_b, zero);
    step("load_a",         1'b0, 1'b0, 1'b0, vec_a, vec_a);
    step("load_b",         1'b0, 1'b0, 1'b0, vec_b, vec_b);
    for (int i = 0; i < 3; i++)
      step("stall_hold_b", 1'b0, 1'b1, 1'b0, vec_a, vec_b);
    step("unstall_a",      1'b0, 1'b0, 1'b0, vec_a, vec_a);
    step("flush_and_stall",1'b0, 1'b1, 1'b1, vec_b, zero);
    step("reload_b",       1'b0, 1'b0, 1'b0, vec_b, vec_b);
    step("rst_midstream",  1'b1, 1'b0, 1'b0, vec_a, zero);
    step("rst_held",       1'b1, 1'b1, 1'b0, vec_b, zero);
    step("rst_over_flush", 1'b1, 1'b0, 1'b1, vec_a, zero);
    step("first_after_rst",1'b0, 1'b0, 1'b0, vec_a, vec_a);
    step("stall_hold_a",   1'b0, 1'b1, 1'b0, vec_b, vec_a);
    step("flush_only",     1'b0, 1'b0, 1'b1, vec_b, zero);
    step("load_after_fl",  1'b0, 1'b0, 1'b0, vec_b, vec_b);

    // Give the monitor a bounded window to drain the last expectations.
    for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected results never observed, required 0", sb_q.size());
    end
    stim_done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
